// File: rtl/dilithium_shake256_stream_sched_pkg.sv
// Shared widths and FSM encoding for the SHAKE256 stream-init engine scheduler.
package dilithium_shake256_stream_sched_pkg;

   localparam int unsigned SEED_W  = 512;
   localparam int unsigned NONCE_W = 16;
   localparam int unsigned STATE_W = 1600;
   localparam int unsigned POS_W   = 32;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RUN      = 3'd1,
      ST_CAPTURE  = 3'd2,
      ST_DELIVER  = 3'd3,
      ST_GAP_WAIT = 3'd4
   } sched_state_t;

endpackage

// File: rtl/dilithium_shake256_stream_sched_rr_arbiter_onehot.sv
// Combinational round-robin pick: first active request at or after ptr, wrapping.
module rr_arbiter_onehot
   import dilithium_shake256_stream_sched_pkg::*;
#(
   parameter int unsigned N_REQ = 3,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt_c,
   output logic [IDX_W-1:0] idx_c
);

   logic             found;
   logic [IDX_W:0]   k;
   logic [IDX_W-1:0] kk;

   always_comb begin
      gnt_c = '0;
      idx_c = '0;
      found = 1'b0;
      k     = '0;
      kk    = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         k = (IDX_W+1)'(ptr) + (IDX_W+1)'(i);
         if (k >= (IDX_W+1)'(N_REQ)) k = k - (IDX_W+1)'(N_REQ);
         kk = k[IDX_W-1:0];
         if (!found && req[kk]) begin
            found     = 1'b1;
            gnt_c[kk] = 1'b1;
            idx_c     = kk;
         end
      end
   end

endmodule

// File: rtl/dilithium_shake256_stream_sched.sv
// Shares one SHAKE256 stream-init engine among N_REQ requesters, round-robin,
// with operand latching, result capture and an enforced engine recovery gap.
module dilithium_shake256_stream_sched
   import dilithium_shake256_stream_sched_pkg::*;
#(
   parameter int unsigned N_REQ = 3,
   parameter int unsigned GAP   = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req_rtr,
   input  logic [N_REQ*SEED_W-1:0]  req_seed,
   input  logic [N_REQ*NONCE_W-1:0] req_nonce,
   output logic [N_REQ-1:0]         grant_rts,
   output logic [STATE_W-1:0]       state_out,
   output logic [POS_W-1:0]         pos_out,
   output logic                     core_rtr,
   output logic [SEED_W-1:0]        core_seed,
   output logic [NONCE_W-1:0]       core_nonce,
   input  logic [STATE_W-1:0]       core_state,
   input  logic [POS_W-1:0]         core_pos,
   input  logic                     core_rts
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CNT_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

   sched_state_t     state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] gidx;
   logic [N_REQ-1:0] gmask;
   logic [CNT_W-1:0] gap_cnt;

   logic [N_REQ-1:0]   arb_gnt_c;
   logic [IDX_W-1:0]   arb_idx_c;
   logic [SEED_W-1:0]  sel_seed_c;
   logic [NONCE_W-1:0] sel_nonce_c;
   logic [IDX_W-1:0]   ptr_next_c;
   logic [CNT_W-1:0]   gap_dec_c;
   logic               req_live_c;

   rr_arbiter_onehot #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req   (req_rtr),
      .ptr   (ptr),
      .gnt_c (arb_gnt_c),
      .idx_c (arb_idx_c)
   );

   // Operand mux driven by the one-hot winner
   always_comb begin
      sel_seed_c  = '0;
      sel_nonce_c = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (arb_gnt_c[i]) begin
            sel_seed_c  = req_seed[i*SEED_W +: SEED_W];
            sel_nonce_c = req_nonce[i*NONCE_W +: NONCE_W];
         end
      end
   end

   assign ptr_next_c = (gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + IDX_W'(1);
   assign gap_dec_c  = (gap_cnt == '0) ? '0 : gap_cnt - CNT_W'(1);
   assign req_live_c = |(req_rtr & gmask);

   // Gap countdown starts in CAPTURE, the first cycle core_rtr is low
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_IDLE;
         ptr        <= '0;
         gidx       <= '0;
         gmask      <= '0;
         gap_cnt    <= CNT_W'(GAP);
         grant_rts  <= '0;
         state_out  <= '0;
         pos_out    <= '0;
         core_rtr   <= 1'b0;
         core_seed  <= '0;
         core_nonce <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|req_rtr) begin
                  core_seed  <= sel_seed_c;
                  core_nonce <= sel_nonce_c;
                  gidx       <= arb_idx_c;
                  gmask      <= arb_gnt_c;
                  core_rtr   <= 1'b1;
                  state      <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (core_rts) begin
                  core_rtr <= 1'b0;
                  state    <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               state_out <= core_state;
               pos_out   <= core_pos;
               ptr       <= ptr_next_c;
               gap_cnt   <= gap_dec_c;
               if (req_live_c) begin
                  grant_rts <= gmask;
                  state     <= ST_DELIVER;
               end else begin
                  state <= ST_GAP_WAIT;
               end
            end
            ST_DELIVER: begin
               gap_cnt <= gap_dec_c;
               if (!req_live_c) begin
                  grant_rts <= '0;
                  state     <= ST_GAP_WAIT;
               end
            end
            ST_GAP_WAIT: begin
               if (gap_cnt == '0) begin
                  gap_cnt <= CNT_W'(GAP);
                  state   <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_dec_c;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/dilithium_shake256_stream_sched.md
# dilithium_shake256_stream_sched

Round-robin scheduler that shares one `dilithium_shake256_stream_init` engine between `N_REQ` requesters, e.g. the s1/s2 samplers and the mask expander in key generation. Each requester presents a 512-bit seed and a 16-bit nonce. The block grants the engine to one requester at a time, holds the operands stable and runs the engine's level rtr/rts handshake. It returns the finalized 1600-bit Keccak state and its position to the granted requester, then enforces the engine's recovery gap before issuing the next grant.

## Interface
Parameters:
- `N_REQ`, 3: number of requesters (2..8).
- `GAP`, 2: minimum cycles `core_rtr` stays low between jobs.

Ports:
- `clock` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `req_rtr` in `N_REQ`: per-requester request level.
- `req_seed` in `N_REQ*512`: seed for requester i at bits [512i+511:512i].
- `req_nonce` in `N_REQ*16`: nonce for requester i at bits [16i+15:16i].
- `grant_rts` out `N_REQ`: one-hot, result valid for the granted requester.
- `state_out` out 1600: captured finalized state.
- `pos_out` out 32: captured state position.
- `core_rtr` out 1: engine rtr.
- `core_seed` out 512: engine seed.
- `core_nonce` out 16: engine nonce.
- `core_state` in 1600: engine finalized state.
- `core_pos` in 32: engine state position.
- `core_rts` in 1: engine done.

## Operation
State machine:
- **IDLE**: if any `req_rtr` is high, pick the winner round-robin, starting from `ptr`.
  - Latch `req_seed` and `req_nonce` of the winner into `core_seed`/`core_nonce`; record `gidx`.
  - Go to RUN.
- **RUN**: `core_rtr`=1.
  - When `core_rts`=1, go to CAPTURE.
- **CAPTURE** (1 cycle): register `core_state`→`state_out` and `core_pos`→`pos_out`; `core_rtr`=0.
  - If the request is still valid, go to DELIVER; if withdrawn, go to GAP_WAIT.
- **DELIVER**: `grant_rts[gidx]`=1 until `req_rtr[gidx]`=0 is observed.
  - `grant_rts` clears on the next edge; go to GAP_WAIT.
- **GAP_WAIT**: counter from `GAP` down to 0, then go to IDLE.
  - Counting runs from the first cycle `core_rtr` is low, overlapping DELIVER.

Rules:
- `ptr` = `gidx`+1 mod `N_REQ` after each job, whether delivered or aborted.
- Withdrawal: `req_rtr[gidx]` going low during RUN cannot abort the engine. The job completes, the result is captured, `grant_rts` is never asserted, and the job counts as served.
- `core_seed`/`core_nonce` are constant from the IDLE latch until the next IDLE latch. Requester inputs may change freely after the grant.
- A requester whose `req_rtr` falls while it is not granted is simply skipped.
- `core_nonce` is passed unmodified; the engine absorbs its low byte first.
- `state_out`/`pos_out` hold their value until the next CAPTURE.

## Timing
- Reset values:
  - `grant_rts`=0, `core_rtr`=0, `core_seed`=0, `core_nonce`=0, `state_out`=0, `pos_out`=0.
  - `ptr`=0, FSM in IDLE, gap counter=`GAP`.
- Arbitration: `req_rtr` high in IDLE → `core_rtr` high the next cycle.
- Result: `grant_rts` rises 2 cycles after the cycle `core_rts` is first sampled high.
- Back-to-back jobs: next `core_rtr` rise ≥ `GAP`+1 cycles after `core_rtr` fell.
- Reset mid-operation: all state returns to reset values on the next edge. The engine shares `reset`, so no job state survives.
- Simultaneous requests: exactly one grant per job. Under continuous load each requester waits at most `N_REQ`-1 jobs.

## Structure
- Shared package:
  - `SEED_W`=512, `NONCE_W`=16, `STATE_W`=1600, `POS_W`=32.
  - FSM state encoding for IDLE, RUN, CAPTURE, DELIVER, GAP_WAIT.
- Sub-module `rr_arbiter_onehot`:
  - Combinational.
  - Inputs: `req` vector, `ptr`.
  - Outputs: one-hot grant, binary index.
- The engine is instantiated beside this block at the top level and connected through the `core_*` ports.

## Test plan
- **Single request:** requester 1, seed all zero, nonce 0x0102.
  - `core_seed`=0 and `core_nonce`=0x0102 while `core_rtr` is high.
  - `grant_rts`=3'b010.
  - `state_out` equals the model SHAKE256(0^64 ‖ 0x02 ‖ 0x01) finalized state.
  - `grant_rts` drops the cycle after `req_rtr[1]` falls.
- **Simultaneous requests:** `req_rtr`=3'b111 held after reset.
  - Grant order 0,1,2,0.
  - Each gap between a `core_rtr` fall and the next rise is ≥3 cycles.
- **Fairness:** `req_rtr`=3'b101 continuous.
  - Grants alternate 0,2,0,2; requester 1 is never granted.
- **Withdrawal:** requester 0 drops `req_rtr` during RUN.
  - No `grant_rts`; next grant goes to requester 1 if pending, with `ptr` advanced.
- **Operand stability:** change `req_seed[0]` one cycle after the grant.
  - `core_seed` is unchanged; the result matches the original seed.
- **Reset in RUN:** assert `reset` while `core_rtr`=1.
  - All outputs are 0 next cycle.
  - A fresh request then completes normally with `ptr` starting at 0.
